// File: rtl/uart_buffered.sv
// Buffered UART host front end: TX/RX FIFOs between a byte-wide host port and the serial engines.
// Define UART_ERR_STATUS_EN to store per-character error flags in the RX FIFO.
module uart_buffered #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Write,
    input  logic [DATA_W-1:0]         OUT_PORT,
    input  logic [1:0]                Read,
    input  logic [2:0]                ie,
    input  logic [$clog2(RX_DEPTH):0] rx_thresh,
    output logic [7:0]                UART_DS,
    output logic                      UART_INT,
    input  logic                      txe_rdy,
    output logic                      txe_write,
    output logic [DATA_W-1:0]         txe_data,
    input  logic                      rxe_rdy,
    input  logic [DATA_W-1:0]         rxe_data,
    input  logic [2:0]                rxe_status,
    output logic                      rxe_read,
    output logic                      o_dbg_tx_state,
    output logic                      o_dbg_rx_state
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
`ifdef UART_ERR_STATUS_EN
    localparam int RX_W = DATA_W + 3;
`else
    localparam int RX_W = DATA_W;
`endif
    localparam logic [TX_AW:0] TX_CNT_MAX = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_CNT_MAX = (RX_AW + 1)'(RX_DEPTH);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic [DATA_W-1:0] r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]  r_tx_wptr, r_tx_rptr;
    logic [TX_AW:0]    r_tx_cnt;
    logic              r_tx_state, r_tx_ovf;
    logic [RX_W-1:0]   r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]  r_rx_wptr, r_rx_rptr;
    logic [RX_AW:0]    r_rx_cnt;
    logic              r_rx_state, r_rx_ovf;
    logic              r_int;

    logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_load;
    logic              w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_ack;
    logic [RX_W-1:0]   w_rx_entry, w_rx_head;
    logic [2:0]        w_rx_err;
    logic [7:0]        w_status, w_rx_byte;
    logic [RX_AW:0]    w_rx_thr;
    logic              w_int;

    // Full/empty come from registered counts, so a push to a full FIFO is dropped even if a pop coincides.
    assign w_tx_full  = (r_tx_cnt == TX_CNT_MAX);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_push  = Write & ~w_tx_full;
    assign w_tx_load  = rst & (r_tx_state == ST_IDLE) & ~w_tx_empty & txe_rdy;
    assign txe_write  = w_tx_load;
    assign txe_data   = r_tx_mem[r_tx_rptr];

    assign w_rx_full  = (r_rx_cnt == RX_CNT_MAX);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_ack   = rst & (r_rx_state == ST_IDLE) & rxe_rdy;
    assign w_rx_push  = w_rx_ack & ~w_rx_full;
    assign w_rx_pop   = (Read == 2'b01) & ~w_rx_empty;
    assign rxe_read   = w_rx_ack;
    assign w_rx_head  = r_rx_mem[r_rx_rptr];

`ifdef UART_ERR_STATUS_EN
    assign w_rx_entry = {rxe_status, rxe_data};
    assign w_rx_err   = w_rx_empty ? 3'b000 : w_rx_head[DATA_W+2:DATA_W];
`else
    logic w_unused_status;
    assign w_unused_status = ^rxe_status;
    assign w_rx_entry      = rxe_data;
    assign w_rx_err        = 3'b000;
`endif

    assign w_status = {w_tx_empty & (r_tx_state == ST_IDLE), r_tx_ovf, r_rx_ovf,
                       w_rx_err, ~w_tx_full, ~w_rx_empty};

    always_comb begin
        w_rx_byte = '0;
        w_rx_byte[DATA_W-1:0] = w_rx_head[DATA_W-1:0];
        UART_DS = 8'h00;
        if (Read[1])
            UART_DS = w_status;
        else if (Read[0])
            UART_DS = w_rx_byte;
    end

    assign w_rx_thr = (rx_thresh == '0) ? (RX_AW + 1)'(1) : rx_thresh;
    assign w_int    = (ie[0] & (r_rx_cnt >= w_rx_thr)) | (ie[1] & w_status[7]) |
                      (ie[2] & (r_rx_ovf | r_tx_ovf | (|w_rx_err)));

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= OUT_PORT;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_entry;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_cnt   <= '0;
            r_tx_state <= ST_IDLE;
            r_tx_ovf   <= 1'b0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_cnt   <= '0;
            r_rx_state <= ST_IDLE;
            r_rx_ovf   <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_load) r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_load})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            if (r_tx_state == ST_IDLE && w_tx_load)
                r_tx_state <= ST_WAIT;
            else if (r_tx_state == ST_WAIT && !txe_rdy)
                r_tx_state <= ST_IDLE;

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            if (r_rx_state == ST_IDLE && w_rx_ack)
                r_rx_state <= ST_WAIT;
            else if (r_rx_state == ST_WAIT && !rxe_rdy)
                r_rx_state <= ST_IDLE;

            // A status read clears the sticky flags, but a new overflow in the same cycle wins.
            r_tx_ovf <= (Write & w_tx_full) | (r_tx_ovf & ~Read[1]);
            r_rx_ovf <= (w_rx_ack & w_rx_full) | (r_rx_ovf & ~Read[1]);
            r_int    <= w_int;
        end
    end

    assign UART_INT       = r_int;
    assign o_dbg_tx_state = r_tx_state;
    assign o_dbg_rx_state = r_rx_state;
endmodule

// File: tb/tb_uart_buffered.sv
// Directed self-checking bench for uart_buffered; expected values follow UART_ERR_STATUS_EN when defined.
module tb_uart_buffered;
  logic       clk = 1'b0;
  logic       rst;
  logic       Write;
  logic [7:0] OUT_PORT;
  logic [1:0] Read;
  logic [2:0] ie;
  logic [4:0] rx_thresh;
  logic [7:0] UART_DS;
  logic       UART_INT;
  logic       txe_rdy;
  logic       txe_write;
  logic [7:0] txe_data;
  logic       rxe_rdy;
  logic [7:0] rxe_data;
  logic [2:0] rxe_status;
  logic       rxe_read;
  logic       dbg_tx_state;
  logic       dbg_rx_state;

  int total = 0;
  int bad   = 0;
  int rx_pulses = 0;
  logic [7:0] tx_got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] st;

`ifdef UART_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  uart_buffered dut (
    .clk(clk), .rst(rst), .Write(Write), .OUT_PORT(OUT_PORT), .Read(Read),
    .ie(ie), .rx_thresh(rx_thresh), .UART_DS(UART_DS), .UART_INT(UART_INT),
    .txe_rdy(txe_rdy), .txe_write(txe_write), .txe_data(txe_data),
    .rxe_rdy(rxe_rdy), .rxe_data(rxe_data), .rxe_status(rxe_status),
    .rxe_read(rxe_read), .o_dbg_tx_state(dbg_tx_state), .o_dbg_rx_state(dbg_rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // engine-side monitor on the inactive edge
  always @(negedge clk) begin
    if (txe_write) tx_got_q.push_back(txe_data);
    if (rxe_read) rx_pulses++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(output logic [7:0] v);
    Read = 2'b10;
    #1;
    v = UART_DS;
    Read = 2'b00;
  endtask

  task automatic clear_status();
    Read = 2'b10;
    step();
    Read = 2'b00;
  endtask

  task automatic host_write(input logic [7:0] d, input bit expect_kept);
    OUT_PORT = d;
    Write = 1'b1;
    step();
    Write = 1'b0;
    if (expect_kept) exp_q.push_back(d);
  endtask

  task automatic tx_drain(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      txe_rdy = c[0];
      step();
    end
    txe_rdy = 1'b0;
    step();
  endtask

  task automatic rx_send(input logic [7:0] d, input logic [2:0] s);
    rxe_data = d;
    rxe_status = s;
    rxe_rdy = 1'b1;
    step();
    rxe_rdy = 1'b0;
    step();
  endtask

  task automatic rx_pop_check(input string tag, input logic [7:0] exp);
    Read = 2'b01;
    #1;
    check_val(tag, UART_DS, exp);
    step();
    Read = 2'b00;
  endtask

  task automatic compare_tx(input string tag);
    check_val({tag, "_count"}, tx_got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_got_q.size(); i++)
      check_val(tag, tx_got_q[i], exp_q[i]);
    tx_got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0; Write = 1'b0; OUT_PORT = '0; Read = 2'b00; ie = 3'b000;
    rx_thresh = 5'd0; txe_rdy = 1'b0; rxe_rdy = 1'b0; rxe_data = '0; rxe_status = '0;
    step();
    step();
    check_val("rst_int", UART_INT, 1'b0);
    check_val("rst_txe_write", txe_write, 1'b0);
    check_val("rst_rxe_read", rxe_read, 1'b0);
    read_status(st);
    check_val("rst_status", st, 8'h82);
    rst = 1'b1;
    step();

    // three characters out through a toggling engine
    for (int i = 0; i < 3; i++) host_write(8'h41 + 8'(i), 1'b1);
    tx_got_q.delete();
    tx_drain(12);
    compare_tx("tx_order");
    read_status(st);
    check_val("tx_done_status", st, 8'h82);

    // overfill the TX FIFO
    for (int i = 0; i < 17; i++) host_write(8'h10 + 8'(i), i < 16);
    read_status(st);
    check_val("tx_full_status", st, 8'h40);
    clear_status();
    read_status(st);
    check_val("tx_ovf_cleared", st, 8'h00);
    // push to a full FIFO is dropped even with a same-cycle pop
    OUT_PORT = 8'h99; Write = 1'b1; txe_rdy = 1'b1;
    step();
    Write = 1'b0; txe_rdy = 1'b0;
    read_status(st);
    check_val("tx_full_pushpop", st, 8'h42);
    clear_status();
    tx_drain(40);
    compare_tx("tx_drain");
    read_status(st);
    check_val("tx_drained_status", st, 8'h82);

    // RX level interrupt
    rx_thresh = 5'd4; ie = 3'b001;
    for (int i = 0; i < 3; i++) rx_send(8'h61 + 8'(i), 3'b000);
    check_val("int_below_thresh", UART_INT, 1'b0);
    rxe_data = 8'h64; rxe_status = 3'b000; rxe_rdy = 1'b1;
    step();
    check_val("int_same_cycle", UART_INT, 1'b0);
    rxe_rdy = 1'b0;
    step();
    check_val("int_at_thresh", UART_INT, 1'b1);
    rx_pop_check("rx_data0", 8'h61);
    check_val("int_after_pop_lag", UART_INT, 1'b1);
    step();
    check_val("int_after_pop", UART_INT, 1'b0);
    for (int i = 1; i < 4; i++) rx_pop_check("rx_data", 8'h61 + 8'(i));
    Read = 2'b01;
    step();
    Read = 2'b00;
    read_status(st);
    check_val("rx_pop_empty", st, 8'h82);
    ie = 3'b000;

    // RX overflow
    rx_pulses = 0;
    for (int i = 0; i < 17; i++) rx_send(8'h80 + 8'(i), 3'b000);
    check_val("rx_read_pulses", rx_pulses, 17);
    read_status(st);
    check_val("rx_ovf_status", st, 8'hA3);
    for (int i = 0; i < 16; i++) rx_pop_check("rx_ovf_data", 8'h80 + 8'(i));
    read_status(st);
    check_val("rx_ovf_sticky", st, 8'hA2);
    clear_status();
    read_status(st);
    check_val("rx_ovf_cleared", st, 8'h82);

    // framing error on the head entry
    ie = 3'b100;
    rx_send(8'h55, 3'b010);
    read_status(st);
    check_val("rx_framing_status", st, ERR_EN ? 8'h8B : 8'h83);
    check_val("rx_err_int", UART_INT, ERR_EN ? 1'b1 : 1'b0);
    rx_pop_check("rx_err_data", 8'h55);
    ie = 3'b000;
    step();

    // reset while the TX side is mid-transfer
    for (int i = 0; i < 5; i++) host_write(8'h30 + 8'(i), 1'b0);
    tx_got_q.delete();
    txe_rdy = 1'b1;
    step();
    check_val("tx_in_wait", dbg_tx_state, 1'b1);
    check_val("tx_wait_load", tx_got_q.size(), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    read_status(st);
    check_val("mid_rst_status", st, 8'h82);
    check_val("mid_rst_int", UART_INT, 1'b0);
    check_val("mid_rst_state", dbg_tx_state, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check_val("mid_rst_no_load", tx_got_q.size(), 1);
    txe_rdy = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
